// File: rtl/ws2812_pkg.sv
// ws2812_pkg: shared FSM states, error codes and 12 MHz WS2812 timing.
package ws2812_pkg;
  typedef enum logic [1:0] {SYNC, IDLE, HIGH, LOW} state_t;
  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_SHORT   = 2'd1;
  localparam logic [1:0] ERR_STUCK   = 2'd2;
  localparam logic [1:0] ERR_PARTIAL = 2'd3;
  // Widths in 12 MHz clk cycles; one bit period is T0H+T0L = T1H+T1L.
  localparam int WS_T0H      = 4;
  localparam int WS_T0L      = 11;
  localparam int WS_T1H      = 10;
  localparam int WS_T1L      = 5;
  localparam int WS_THRESH   = 7;
  localparam int WS_MIN_HIGH = 2;
  localparam int WS_MAX_HIGH = 14;
  localparam int WS_RESET    = 600;
endpackage

// File: rtl/ws2812_sync2.sv
// ws2812_sync2: two-flop synchronizer with async reset to 0.
module ws2812_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);
  logic [1:0] s_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) s_q <= '0;
    else     s_q <= {s_q[0], d_i};
  assign q_o = s_q[1];
endmodule

// File: rtl/ws2812_rx.sv
// ws2812_rx: WS2812 NRZ decoder producing 24-bit words, LED index, frame latch and error pulses.
module ws2812_rx
  import ws2812_pkg::*;
#(
  parameter int NUM_LEDS     = 8,
  parameter int BIT_THRESH   = WS_THRESH,
  parameter int MIN_HIGH     = WS_MIN_HIGH,
  parameter int MAX_HIGH     = WS_MAX_HIGH,
  parameter int RESET_CYCLES = WS_RESET
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        din,
  output logic [23:0] rgb_data,
  output logic [7:0]  led_num,
  output logic        valid,
  output logic        frame_done,
  output logic [7:0]  frame_leds,
  output logic        err,
  output logic [1:0]  err_code
);
  localparam int CW = $clog2(RESET_CYCLES + 1);
  localparam logic [CW-1:0] L_RST = CW'(RESET_CYCLES);
  localparam logic [CW-1:0] L_MIN = CW'(MIN_HIGH);
  localparam logic [CW-1:0] L_MAX = CW'(MAX_HIGH);
  localparam logic [CW-1:0] L_THR = CW'(BIT_THRESH);
  localparam logic [CW-1:0] L_ONE = CW'(1);
  localparam logic [8:0]    L_NUM = 9'(NUM_LEDS);

  logic          din_s;
  state_t        state_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    bit_cnt_q;
  logic [7:0]    word_cnt_q, word_cnt_d;
  logic [23:0]   shreg_q, rgb_q;
  logic [7:0]    led_num_q, frame_leds_q;
  logic          valid_q, frame_done_q, err_q;
  logic [1:0]    err_code_q;
  logic          at_rst, bad_w, bit_v, last;

  ws2812_sync2 u_sync (.clk(clk), .rst(reset), .d_i(din), .q_o(din_s));

  always_comb begin
    cnt_d      = (cnt_q == '1) ? cnt_q : cnt_q + L_ONE;
    word_cnt_d = (word_cnt_q == 8'hFF) ? word_cnt_q : word_cnt_q + 8'd1;
    at_rst     = cnt_d == L_RST;
    bad_w      = cnt_q < L_MIN || cnt_q > L_MAX;
    bit_v      = cnt_q >= L_THR;
    last       = bit_cnt_q == 5'd23;
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q      <= SYNC;
      cnt_q        <= '0;
      bit_cnt_q    <= '0;
      word_cnt_q   <= '0;
      shreg_q      <= '0;
      rgb_q        <= '0;
      led_num_q    <= '0;
      frame_leds_q <= '0;
      err_code_q   <= ERR_NONE;
      valid_q      <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      valid_q      <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
      case (state_q)
        SYNC: begin
          cnt_q <= din_s ? '0 : cnt_d;
          if (!din_s && at_rst) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end
        end
        IDLE: if (din_s) begin
          cnt_q   <= L_ONE;
          state_q <= HIGH;
        end
        HIGH: if (din_s) begin
          cnt_q <= cnt_d;
          if (at_rst) begin
            err_q      <= 1'b1;
            err_code_q <= ERR_STUCK;
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
            shreg_q    <= '0;
            cnt_q      <= '0;
            state_q    <= SYNC;
          end
        end else begin
          cnt_q   <= L_ONE;
          state_q <= LOW;
          if (bad_w) begin
            err_q      <= 1'b1;
            err_code_q <= ERR_SHORT;
          end else begin
            shreg_q <= {shreg_q[22:0], bit_v};
            if (last) begin
              rgb_q      <= {shreg_q[22:0], bit_v};
              led_num_q  <= word_cnt_q;
              valid_q    <= {1'b0, word_cnt_q} < L_NUM;
              word_cnt_q <= word_cnt_d;
              bit_cnt_q  <= '0;
            end else begin
              bit_cnt_q <= bit_cnt_q + 5'd1;
            end
          end
        end
        LOW: if (din_s) begin
          cnt_q   <= L_ONE;
          state_q <= HIGH;
        end else begin
          cnt_q <= cnt_d;
          if (at_rst) begin
            frame_done_q <= 1'b1;
            frame_leds_q <= word_cnt_q;
            if (bit_cnt_q != '0) begin
              err_q      <= 1'b1;
              err_code_q <= ERR_PARTIAL;
            end
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
            shreg_q    <= '0;
            cnt_q      <= '0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= SYNC;
      endcase
    end

  assign rgb_data   = rgb_q;
  assign led_num    = led_num_q;
  assign valid      = valid_q;
  assign frame_done = frame_done_q;
  assign frame_leds = frame_leds_q;
  assign err        = err_q;
  assign err_code   = err_code_q;
endmodule

// File: doc/ws2812_rx.md
# ws2812_rx

Decoder for the single-wire WS2812 NRZ protocol: the receiving end of the `ws2812` transmitter. It samples the serial line, classifies each high pulse as a 0 or 1 by its width, and assembles 24-bit words. It presents each word with its LED index and reports frame-latch gaps and line errors. It is used for loopback self-test of `ws2812` on a spare pmod pin and for receiving LED data from external controllers.

## Interface

**Parameters**
- `NUM_LEDS`, default 8: words emitted per frame; later words are counted but not emitted.
- `BIT_THRESH`, default 7: high width in clk cycles at or above which a bit decodes as 1 (12 MHz: 0.58 µs).
- `MIN_HIGH`, default 2: high widths below this are glitches.
- `MAX_HIGH`, default 14: high widths above this are errors.
- `RESET_CYCLES`, default 600: low cycles that mark a frame latch (50 µs at 12 MHz).

**Ports**
- `clk` input 1: system clock.
- `reset` input 1: asynchronous, active-high reset.
- `din` input 1: WS2812 serial line, asynchronous to `clk`.
- `rgb_data` output 24: last decoded word in wire order; the first received bit is bit 23.
- `led_num` output 8: index of the word in `rgb_data` within its frame, starting at 0.
- `valid` output 1: one-cycle pulse; `rgb_data` and `led_num` are new.
- `frame_done` output 1: one-cycle pulse on latch gap after at least one bit.
- `frame_leds` output 8: complete words in the frame just ended, saturating at 255; valid when `frame_done` is high.
- `err` output 1: one-cycle error pulse.
- `err_code` output 2: 1 = short pulse, 2 = stuck high, 3 = partial word at latch. Holds until the next `err`.

## Operation

- `din` passes through a two-flop synchronizer; `din_s` is its output. All decisions use `din_s`.
- Counters:
  - `cnt`: time counter, `$clog2(RESET_CYCLES+1)` bits, saturating.
  - `bit_cnt`: 0..23.
  - `word_cnt`: 8 bits, saturating at 255.
  - `shreg`: 24 bits, shifts left with the new bit in at bit 0.
- **SYNC** (state after reset):
  - `din_s`=1 clears `cnt`; `din_s`=0 increments it.
  - When `cnt` reaches `RESET_CYCLES`: go to IDLE, no `frame_done`.
- **IDLE**: when `din_s`=1, set `cnt`=1 and go to HIGH.
- **HIGH**:
  - While `din_s`=1, increment `cnt`. If `cnt` reaches `RESET_CYCLES`: `err`, code 2; clear `bit_cnt`, `word_cnt`, `shreg`; go to SYNC.
  - On `din_s`=0 with width w = `cnt`:
    - If w < `MIN_HIGH` or w > `MAX_HIGH`: `err`, code 1; the bit is discarded and `bit_cnt` is unchanged.
    - Otherwise shift in bit (w >= `BIT_THRESH`).
    - If that is the 24th bit: latch `rgb_data` = {shreg[22:0], bit} and `led_num` = `word_cnt` (saturated); assert `valid` only if `word_cnt` < `NUM_LEDS`; then increment `word_cnt` and clear `bit_cnt`.
    - Set `cnt`=1 and go to LOW.
- **LOW**:
  - `din_s`=1: set `cnt`=1 and go to HIGH.
  - Otherwise increment `cnt`. When `cnt` reaches `RESET_CYCLES`:
    - `frame_done`=1, `frame_leds`=`word_cnt`.
    - If `bit_cnt`≠0: `err`, code 3.
    - Clear `bit_cnt`, `word_cnt`, `shreg`; go to IDLE.
- When a short-pulse error and a 24th bit would coincide, the error wins and no word is produced.
- `valid` and `err` are never both high in the same cycle. `frame_done` and `err` code 3 are high in the same cycle.

## Timing

- Reset values:
  - `rgb_data`=0, `led_num`=0, `frame_leds`=0, `err_code`=0.
  - `valid`=0, `frame_done`=0, `err`=0.
  - State SYNC; all counters 0.
- Reset may assert mid-word: the partial word is dropped with no pulses, and the block restarts in SYNC.
- Latency: `din` falling → `valid`/`err` registered on the 3rd clk edge (2 sync + 1 FSM).
- Latency: latch gap → `frame_done` on the clk edge where `cnt` reaches `RESET_CYCLES`, about `RESET_CYCLES`+2 edges after the last falling `din`.
- Width measure: a `din_s` high of N cycles yields w = N exactly.
- No backpressure. The consumer must accept `valid` in the cycle it is high. Minimum spacing between `valid` pulses is 24 × (`MIN_HIGH`+1) cycles.

## Structure

- Package `ws2812_pkg`:
  - FSM state enum (SYNC, IDLE, HIGH, LOW).
  - `err_code` constants (ERR_NONE, ERR_SHORT, ERR_STUCK, ERR_PARTIAL).
  - 12 MHz default timing constants, shared with `ws2812`.
- Sub-module `ws2812_sync2`: two-flop synchronizer with async reset to 0, reused by other pmod inputs.

## Test plan

- After reset, hold `din` low 600 cycles, then send 24 bits 0x100000 (high 10/low 5 for 1, high 4/low 11 for 0), then low 600 cycles → `valid`, `rgb_data`=0x100000, `led_num`=0; `frame_done`, `frame_leds`=1.
- Loopback from `ws2812` (NUM_LEDS=8), cycling colours 0x100000/0x001000/0x000010/0x101010 → 8 `valid` per frame with `led_num` 0..7, data matching the sent colour, `frame_leds`=8, no `err`.
- Send 10 words with NUM_LEDS=8 → `valid` for indices 0..7 only; `frame_leds`=10.
- 1-cycle glitch inside a word → `err`, `err_code`=1; the word completes after 24 good bits.
- 12 bits then a 600-cycle gap → `frame_done`, `err`, `err_code`=3, `frame_leds`=0. Hold `din` high 600 cycles → `err`, `err_code`=2; no decode until 600 low cycles pass.
- Assert `reset` after 12 bits of a word → all outputs return to reset values immediately; the next full frame decodes correctly.
